// File: rtl/bus_pkg.sv
// Shared definitions for the bus arbiter/mux slice.
//   ARB_PRIO / ARB_RR : arbitration mode constants for the MODE parameter
//   arb_state_e       : arbiter FSM state (IDLE, OWNED)
//   DEF_N_SRC/DEF_DATA_W : default driver count and bus width
//   own_w()           : width of a source index, never less than 1
package bus_pkg;

  localparam int ARB_PRIO   = 0;
  localparam int ARB_RR     = 1;
  localparam int DEF_N_SRC  = 5;
  localparam int DEF_DATA_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_e;

  function automatic int own_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_rr_pick.sv
// Combinational rotating-priority picker.
//   req     : request vector
//   ptr     : index searched first; search proceeds upward, wrapping to 0
//   win     : one-hot winner (0 when no request)
//   win_idx : winner index (0 when no request)
//   any     : at least one request
// Fixed priority is the same search with ptr tied to 0.
module bus_rr_pick
  import bus_pkg::*;
#(
  parameter int N_SRC = DEF_N_SRC,
  parameter int OWN_W = own_w(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  input  logic [OWN_W-1:0] ptr,
  output logic [N_SRC-1:0] win,
  output logic [OWN_W-1:0] win_idx,
  output logic             any
);

  always_comb begin
    int j;
    j       = 0;
    win     = '0;
    win_idx = '0;
    any     = |req;
    // Walk the search order backwards so the last hit written is the
    // first one in order from ptr.
    for (int k = N_SRC - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N_SRC) j = j - N_SRC;
      if (req[j]) begin
        win     = '0;
        win[j]  = 1'b1;
        win_idx = OWN_W'(j);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_mux.sv
// Parametrised bus arbiter and registered data mux.
//   clk, rst_n        : clock, asynchronous active-low reset
//   src_en            : per-source drive request
//   src_data          : flattened source data, source i at [i*DATA_W +: DATA_W]
//   lock              : keep the current grant beyond one cycle
//   clr_sticky        : clears contention_sticky (and contention_count)
//   bus_data/bus_valid: registered bus value and its valid flag
//   grant/bus_owner   : registered one-hot grant and owner index (0 when idle)
//   contention        : registered: more than one src_en high last cycle
//   contention_sticky : latched contention, set wins over clear
// Optional: define BUS_ARBITER_CONTENTION_CNT_EN to add a saturating
// contention_count[CNT_W] output.
module bus_arbiter_mux
  import bus_pkg::*;
#(
  parameter  int N_SRC  = DEF_N_SRC,
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int MODE   = ARB_PRIO,
  parameter  int CNT_W  = 8,
  localparam int OWN_W  = own_w(N_SRC)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_SRC-1:0]        src_en,
  input  logic [N_SRC*DATA_W-1:0] src_data,
  input  logic                    lock,
  input  logic                    clr_sticky,
  output logic [DATA_W-1:0]       bus_data,
  output logic                    bus_valid,
  output logic [N_SRC-1:0]        grant,
  output logic [OWN_W-1:0]        bus_owner,
  output logic                    contention,
`ifdef BUS_ARBITER_CONTENTION_CNT_EN
  output logic [CNT_W-1:0]        contention_count,
`endif
  output logic                    contention_sticky
);

  if (N_SRC < 1 || DATA_W < 1 || CNT_W < 1) begin : g_bad_param
    $error("bus_arbiter_mux: N_SRC, DATA_W and CNT_W must be >= 1");
  end

  arb_state_e       state;
  logic [OWN_W-1:0] rr_ptr;

  logic [N_SRC-1:0] pick_win;
  logic [OWN_W-1:0] pick_idx;
  logic             pick_any;
  logic [OWN_W-1:0] pick_ptr;
  logic [OWN_W-1:0] ptr_nxt;
  logic             hold;
  logic             multi;
  logic [OWN_W-1:0] sel_idx;
  logic [DATA_W-1:0] sel_data;

  assign pick_ptr = (MODE == ARB_RR) ? rr_ptr : '0;

  bus_rr_pick #(.N_SRC(N_SRC), .OWN_W(OWN_W)) u_pick (
    .req     (src_en),
    .ptr     (pick_ptr),
    .win     (pick_win),
    .win_idx (pick_idx),
    .any     (pick_any)
  );

  // Ownership survives only while both lock and the owner's request stay
  // up; otherwise this cycle is arbitrated like IDLE (no bubble).
  assign hold     = (state == OWNED) && lock && src_en[bus_owner];
  // More than one bit set: clearing the lowest set bit leaves something.
  assign multi    = |(src_en & (src_en - N_SRC'(1)));
  assign sel_idx  = hold ? bus_owner : pick_idx;
  assign sel_data = src_data[sel_idx*DATA_W +: DATA_W];
  assign ptr_nxt  = (pick_idx == OWN_W'(N_SRC - 1)) ? '0 : pick_idx + OWN_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      rr_ptr            <= '0;
      bus_data          <= '0;
      bus_valid         <= 1'b0;
      grant             <= '0;
      bus_owner         <= '0;
      contention        <= 1'b0;
      contention_sticky <= 1'b0;
    end else begin
      contention        <= multi;
      contention_sticky <= multi | (contention_sticky & ~clr_sticky);
      if (hold) begin
        bus_data  <= sel_data;
        bus_valid <= 1'b1;
      end else if (pick_any) begin
        bus_data  <= sel_data;
        bus_valid <= 1'b1;
        grant     <= pick_win;
        bus_owner <= pick_idx;
        state     <= lock ? OWNED : IDLE;
        if (MODE == ARB_RR) rr_ptr <= ptr_nxt;
      end else begin
        bus_data  <= '0;
        bus_valid <= 1'b0;
        grant     <= '0;
        bus_owner <= '0;
        state     <= IDLE;
      end
    end
  end

`ifdef BUS_ARBITER_CONTENTION_CNT_EN
  // Counts the same events that set contention; clear beats increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   contention_count <= '0;
    else if (clr_sticky)          contention_count <= '0;
    else if (multi && !(&contention_count))
      contention_count <= contention_count + CNT_W'(1);
  end
`endif

endmodule

// File: doc/bus_arbiter_mux.md
Name: bus_arbiter_mux

Overview:
- Parametrised successor to the single-cycle priority bus mux: N sources, W-bit data, registered output.
- Arbitrates among requesting drivers in fixed-priority or round-robin mode and supports multi-cycle bus ownership via a lock handshake.
- Detects and flags driver contention.
- Sits at the centre of the datapath; all drivers (IR, adder, A, memory, PC, future additions) connect as indexed sources.

Parameters:
- N_SRC, 5, number of bus drivers (>=1).
- DATA_W, 8, bus data width.
- MODE, 0, arbitration mode: 0 = fixed priority (lowest index wins), 1 = round-robin.
- CNT_W, 8, contention counter width (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- src_en  in  N_SRC  per-source drive request.
- src_data  in  N_SRC*DATA_W  flattened source data; source i occupies bits [i*DATA_W +: DATA_W].
- lock  in  1  request to hold the current grant beyond one cycle.
- clr_sticky  in  1  clears contention_sticky.
- bus_data  out  DATA_W  registered bus value.
- bus_valid  out  1  bus_data is driven by a granted source.
- grant  out  N_SRC  registered one-hot grant, aligned with bus_data.
- bus_owner  out  OWN_W = max(1, clog2(N_SRC))  index of the granted source; 0 when idle.
- contention  out  1  registered pulse: more than one src_en was high in the previous cycle.
- contention_sticky  out  1  latched contention flag.

Behaviour:
- Reset (async, rst_n=0): bus_data=0, bus_valid=0, grant=0, bus_owner=0, contention=0, contention_sticky=0, rr_ptr=0, state=IDLE.
- Latency: 1 cycle. Inputs sampled at edge k appear on the outputs after edge k.
- FSM states:
  - IDLE: no active lock.
  - OWNED: a source holds the bus.
- IDLE with no src_en:
  - bus_data<=0, bus_valid<=0, grant<=0, bus_owner<=0. Matches the legacy default of zero.
- IDLE with any src_en: choose winner w.
  - MODE=0: w is the lowest index with src_en set.
  - MODE=1: w is the first set index searching from rr_ptr upward, wrapping N_SRC-1 to 0.
  - bus_data<=src_data[w], bus_valid<=1, grant<=1<<w, bus_owner<=w.
  - MODE=1 only: rr_ptr<=(w+1) mod N_SRC; wrap from N_SRC-1 goes to 0.
  - If lock=1 in the same cycle: next state is OWNED with owner=w.
- OWNED:
  - Each cycle: bus_data<=src_data[owner], grant and bus_owner unchanged, bus_valid<=1.
  - Other requests are ignored for arbitration.
  - rr_ptr does not advance.
- OWNED to IDLE when lock=0 or src_en[owner]=0 (either releases ownership).
  - The release cycle itself is arbitrated as IDLE, so a new winner is granted with no bubble.
  - If src_en[owner]=0 and lock=1, the owner is not re-granted unless it wins normal arbitration.
- Contention:
  - contention<=1 when popcount(src_en)>1, independent of state and lock; otherwise 0.
  - contention_sticky is set by contention and cleared by clr_sticky. If set and clear coincide, set wins.
- N_SRC=1: round-robin degenerates to a single source; rr_ptr stays 0; contention is never asserted.
- Reset mid-OWNED: immediate return to reset values. Lock is not remembered.

Optional Feature:
- Macro: BUS_ARBITER_CONTENTION_CNT_EN.
- Defined:
  - Adds output contention_count [CNT_W].
  - The counter increments on each cycle contention is registered high and saturates at all-ones.
  - clr_sticky also clears it; clear wins over increment for the counter only.
  - Reset value 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package bus_pkg:
  - mode constants (ARB_PRIO=0, ARB_RR=1);
  - arbiter state enum (IDLE, OWNED);
  - default DATA_W/N_SRC localparams.
- One natural sub-module: bus_rr_pick.
  - Purely combinational: request vector plus start pointer in, one-hot winner and index out.
  - Used for both modes; MODE=0 drives the pointer with constant 0.

Test Plan:
- Reset, MODE=0, N_SRC=5, W=8: src_en=5'b00000 -> bus_data=0x00, bus_valid=0, grant=0 on every cycle.
- MODE=0: src_en=5'b10110, data[1]=0x3C, data[2]=0x55 -> next cycle bus_data=0x3C, grant=5'b00010, bus_owner=1, contention=1, contention_sticky=1.
- MODE=1, all five requesting for 6 cycles -> bus_owner sequence 0,1,2,3,4,0 (wrap verified); contention high throughout.
- Lock: src 3 alone with lock=1 for 4 cycles, data changing 0x10,0x11,0x12,0x13, src 0 raising src_en in cycle 2 -> grant stays 5'b01000, bus_data follows 0x10..0x13. Then lock=0 -> the next cycle grants src 0.
- Sticky and reset:
  - clr_sticky and a contention event in the same cycle -> contention_sticky stays 1.
  - Assert rst_n=0 mid-OWNED -> all outputs 0 asynchronously, before the next clk edge.
- With BUS_ARBITER_CONTENTION_CNT_EN, CNT_W=2: 5 contention cycles -> contention_count=3 (saturated). clr_sticky -> 0.
